// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : shared colour, RGB565 field and 640x480 geometry definitions
// Rev 1.0
// ============================================================================
package vga_pkg;

    localparam int CH_W  = 4;
    localparam int RGB_W = 3 * CH_W;

    // Top bits of each RGB565 field feed the 4-bit DAC channels
    localparam int R565_MSB = 15;
    localparam int G565_MSB = 10;
    localparam int B565_MSB = 4;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb444_t;

    function automatic rgb444_t rgb565_to_444(input logic [15:0] d);
        rgb444_t c;
        c.r = d[R565_MSB -: CH_W];
        c.g = d[G565_MSB -: CH_W];
        c.b = d[B565_MSB -: CH_W];
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// vga_delay_line : DEPTH-stage shift register with a synchronous reset value
// Rev 1.0
// ============================================================================
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= RST_VAL;
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign dout = taps[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_fb_fetch.sv
`default_nettype none
// ============================================================================
// vga_fb_fetch : framebuffer address generation and RGB565 -> VGA realignment
// Rev 1.0
// ============================================================================
module vga_fb_fetch
    import vga_pkg::*;
#(
    parameter int          IMG_W      = 160,
    parameter int          IMG_H      = 120,
    parameter int          SCALE_LOG2 = 2,
    parameter int          WIN_X0     = 0,
    parameter int          WIN_Y0     = 0,
    parameter int          RD_LAT     = 2,
    parameter logic [11:0] BG_RGB     = 12'h000,
    parameter bit          H_POL      = 1'b0,
    parameter bit          V_POL      = 1'b0
) (
    input  logic               i_pix_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic signed [15:0] i_sx,
    input  logic signed [15:0] i_sy,
    input  logic               i_hs,
    input  logic               i_vs,
    input  logic               i_de,
    input  logic               i_frame,
    output logic        [14:0] o_addrb,
    input  logic        [15:0] i_doutb,
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_de,
    output logic         [3:0] o_r,
    output logic         [3:0] o_g,
    output logic         [3:0] o_b
);

    localparam logic signed [15:0] X_LO   = 16'(WIN_X0);
    localparam logic signed [15:0] X_HI   = 16'(WIN_X0 + (IMG_W << SCALE_LOG2));
    localparam logic signed [15:0] X_LAST = 16'(WIN_X0 + (IMG_W << SCALE_LOG2) - 1);
    localparam logic signed [15:0] Y_LO   = 16'(WIN_Y0);
    localparam logic signed [15:0] Y_HI   = 16'(WIN_Y0 + (IMG_H << SCALE_LOG2));
    localparam int                 SUB_W  = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
    localparam logic [SUB_W-1:0]   SUB_LAST = SUB_W'((1 << SCALE_LOG2) - 1);
    localparam logic [14:0]        ROW_STEP = 15'(IMG_W);
    localparam logic [14:0]        ROW_MAX  = 15'((IMG_H - 1) * IMG_W);

    if (IMG_W * IMG_H > 32768) begin : g_size_check
        $error("vga_fb_fetch: IMG_W*IMG_H does not fit the 15-bit address");
    end
    if (RD_LAT < 1 || RD_LAT > 3) begin : g_lat_check
        $error("vga_fb_fetch: RD_LAT must be 1..3");
    end

    logic signed [15:0] sx_s0, sy_s0;
    logic               hs_s0, vs_s0, de_s0, en_s0, frame_s0;

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            sx_s0    <= '0;
            sy_s0    <= '0;
            hs_s0    <= ~H_POL;
            vs_s0    <= ~V_POL;
            de_s0    <= 1'b0;
            en_s0    <= 1'b0;
            frame_s0 <= 1'b0;
        end else begin
            sx_s0    <= i_sx;
            sy_s0    <= i_sy;
            hs_s0    <= i_hs;
            vs_s0    <= i_vs;
            de_s0    <= i_de;
            en_s0    <= i_en;
            frame_s0 <= i_frame;
        end
    end

    logic             in_win, eol;
    logic      [15:0] x_off;
    logic      [14:0] col_off;
    logic      [14:0] row_base;
    logic [SUB_W-1:0] sub_line;

    assign in_win  = (sx_s0 >= X_LO) && (sx_s0 < X_HI) && (sy_s0 >= Y_LO) && (sy_s0 < Y_HI);
    assign eol     = in_win && (sx_s0 == X_LAST);
    assign x_off   = sx_s0 - X_LO;
    assign col_off = 15'(x_off >> SCALE_LOG2);

    // Row base advances by one source row every 2**SCALE_LOG2 screen lines;
    // saturation keeps a missed frame pulse from running past the image.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            o_addrb  <= '0;
            row_base <= '0;
            sub_line <= '0;
        end else begin
            if (in_win) o_addrb <= row_base + col_off;
            if (frame_s0) begin
                row_base <= '0;
                sub_line <= '0;
            end else if (eol) begin
                if (sub_line == SUB_LAST) begin
                    sub_line <= '0;
                    row_base <= (row_base < ROW_MAX) ? row_base + ROW_STEP : ROW_MAX;
                end else begin
                    sub_line <= sub_line + SUB_W'(1);
                end
            end
        end
    end

    logic [4:0]  dly_out;
    logic        de_d, en_d, win_d;
    logic [15:0] pix;
    rgb444_t     colour;

    vga_delay_line #(
        .WIDTH   (5),
        .DEPTH   (RD_LAT + 1),
        .RST_VAL ({~H_POL, ~V_POL, 3'b000})
    ) u_sync_dly (
        .clk  (i_pix_clk),
        .rst  (i_rst),
        .din  ({hs_s0, vs_s0, de_s0, en_s0, in_win}),
        .dout (dly_out)
    );

    assign {o_hs, o_vs, de_d, en_d, win_d} = dly_out;
    assign o_de = de_d;

    // Captured on the same edge the delay line's last tap loads
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) pix <= '0;
        else       pix <= i_doutb;
    end

    always_comb begin
        colour = '0;
        if (de_d && en_d && win_d) colour = rgb565_to_444(pix);
        else if (de_d)             colour = rgb444_t'(BG_RGB);
    end

    assign o_r = colour.r;
    assign o_g = colour.g;
    assign o_b = colour.b;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_fetch.sv
`default_nettype none
// ============================================================================
// tb_vga_fb_fetch : scoreboard bench for vga_fb_fetch (default and windowed)
// Rev 1.0
// ============================================================================
module tb_vga_fb_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, en, hs, vs, de, frame;
    logic signed [15:0] sx, sy;
    logic        [14:0] addr_a, addr_b;
    logic        [15:0] dout_a, dout_b;
    logic               hs_a, vs_a, de_a, hs_b, vs_b, de_b;
    logic         [3:0] r_a, g_a, b_a, r_b, g_b, b_b;

    vga_fb_fetch dut_a (
        .i_pix_clk(clk), .i_rst(rst), .i_en(en), .i_sx(sx), .i_sy(sy),
        .i_hs(hs), .i_vs(vs), .i_de(de), .i_frame(frame),
        .o_addrb(addr_a), .i_doutb(dout_a),
        .o_hs(hs_a), .o_vs(vs_a), .o_de(de_a), .o_r(r_a), .o_g(g_a), .o_b(b_a)
    );

    vga_fb_fetch #(.WIN_X0(100), .WIN_Y0(50), .BG_RGB(12'h00F)) dut_b (
        .i_pix_clk(clk), .i_rst(rst), .i_en(en), .i_sx(sx), .i_sy(sy),
        .i_hs(hs), .i_vs(vs), .i_de(de), .i_frame(frame),
        .o_addrb(addr_b), .i_doutb(dout_b),
        .o_hs(hs_b), .o_vs(vs_b), .o_de(de_b), .o_r(r_b), .o_g(g_b), .o_b(b_b)
    );

    function automatic logic [15:0] bram_word(input logic [14:0] a);
        if (a == 15'd0) return 16'hF81F;
        return {a[7:0], ~a[14:7]} ^ 16'h3C5A;
    endfunction

    // RD_LAT = 2: one register here after the DUT's registered address
    always_ff @(posedge clk) begin
        dout_a <= bram_word(addr_a);
        dout_b <= bram_word(addr_b);
    end

    typedef struct { int due; string tag; logic [14:0] addr; } addr_exp_t;
    typedef struct { int due; string tag; logic [14:0] v; } out_exp_t;

    addr_exp_t qa_addr[$], qb_addr[$];
    out_exp_t  qa_out[$],  qb_out[$];

    int checks = 0;
    int errors = 0;
    int step   = 0;
    int last_a = 0;

    function automatic bit win_a(int x, int y);
        return x >= 0 && x < 640 && y >= 0 && y < 480;
    endfunction
    function automatic bit win_b(int x, int y);
        return x >= 100 && x < 740 && y >= 50 && y < 530;
    endfunction
    function automatic int raster(int x, int y, int x0, int y0);
        return ((y - y0) / 4) * 160 + (x - x0) / 4;
    endfunction

    // Packed {hs, vs, de, r, g, b} expected for one pixel
    function automatic logic [14:0] exp_out(logic h, logic v, logic d, logic e, bit w,
                                            logic [14:0] a, logic [11:0] bg);
        logic [15:0] wd;
        logic [11:0] c;
        wd = bram_word(a);
        if (d && e && w) c = {wd[15:12], wd[10:7], wd[4:1]};
        else if (d)      c = bg;
        else             c = 12'h000;
        return {h, v, d, c};
    endfunction

    task automatic cmp(input string tag, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s @step %0d: got 'h%0h expected 'h%0h", tag, step, got, exp);
        end
    endtask

    task automatic check_due();
        addr_exp_t ea;
        out_exp_t  eo;
        while (qa_addr.size() > 0 && qa_addr[0].due == step) begin
            ea = qa_addr.pop_front(); cmp(ea.tag, addr_a, ea.addr);
        end
        while (qb_addr.size() > 0 && qb_addr[0].due == step) begin
            ea = qb_addr.pop_front(); cmp(ea.tag, addr_b, ea.addr);
        end
        while (qa_out.size() > 0 && qa_out[0].due == step) begin
            eo = qa_out.pop_front(); cmp(eo.tag, {hs_a, vs_a, de_a, r_a, g_a, b_a}, eo.v);
        end
        while (qb_out.size() > 0 && qb_out[0].due == step) begin
            eo = qb_out.pop_front(); cmp(eo.tag, {hs_b, vs_b, de_b, r_b, g_b, b_b}, eo.v);
        end
    endtask

    task automatic drive(input int x, input int y, input logic d, input logic h, input logic v,
                         input logic e, input logic f, input logic r, input bit ca, input bit cb,
                         input int ovr = -1);
        int ab;
        if (r) begin
            qa_addr.delete(); qb_addr.delete(); qa_out.delete(); qb_out.delete();
            last_a = 0;
        end
        rst = r; sx = 16'(x); sy = 16'(y); de = d; hs = h; vs = v; en = e; frame = f;
        if (!r) begin
            if (win_a(x, y)) last_a = (ovr >= 0) ? ovr : raster(x, y, 0, 0);
            if (ca) begin
                qa_addr.push_back('{due: step + 2, tag: $sformatf("A_addr(%0d,%0d)", x, y),
                                    addr: 15'(last_a)});
                qa_out.push_back('{due: step + 4, tag: $sformatf("A_out(%0d,%0d)", x, y),
                                   v: exp_out(h, v, d, e, win_a(x, y), 15'(last_a), 12'h000)});
            end
            if (cb) begin
                ab = win_b(x, y) ? raster(x, y, 100, 50) : 0;
                if (win_b(x, y))
                    qb_addr.push_back('{due: step + 2, tag: $sformatf("B_addr(%0d,%0d)", x, y),
                                        addr: 15'(ab)});
                qb_out.push_back('{due: step + 4, tag: $sformatf("B_out(%0d,%0d)", x, y),
                                   v: exp_out(h, v, d, e, win_b(x, y), 15'(ab), 12'h00F)});
            end
        end
        @(negedge clk);
        step++;
        check_due();
    endtask

    task automatic run_px(input int y, input int x0, input int x1, input logic e,
                          input bit ca, input bit cb);
        for (int x = x0; x <= x1; x++) drive(x, y, 1'b1, 1'b1, 1'b1, e, 1'b0, 1'b0, ca, cb);
    endtask

    task automatic hblank(input int y, input bit ca, input bit cb);
        drive(-1, y, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ca, cb);
    endtask

    task automatic vblank_frame(input bit ca, input bit cb);
        for (int i = 0; i < 4; i++)
            drive(-8 + i, -2, 1'b0, 1'b1, (i < 2) ? 1'b0 : 1'b1, 1'b1, (i == 3), 1'b0, ca, cb);
    endtask

    task automatic check_reset(input string tag);
        cmp({tag, "_addr_a"}, addr_a, 15'd0);
        cmp({tag, "_out_a"},  {hs_a, vs_a, de_a, r_a, g_a, b_a}, {3'b110, 12'h000});
        cmp({tag, "_addr_b"}, addr_b, 15'd0);
        cmp({tag, "_out_b"},  {hs_b, vs_b, de_b, r_b, g_b, b_b}, {3'b110, 12'h000});
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; hs = 1'b1; vs = 1'b1; de = 1'b0; frame = 1'b0;
        sx = '0; sy = '0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) drive(-1, -1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0);
        check_reset("rst_init");

        // Frame start, first line: sx 0..7 then the line end
        vblank_frame(1, 0);
        hblank(0, 1, 0);
        run_px(0, 0, 7, 1'b1, 1, 0);
        run_px(0, 636, 639, 1'b1, 1, 0);
        hblank(0, 1, 0);
        for (int y = 1; y < 4; y++) begin
            run_px(y, 636, 639, 1'b1, 1, 0);
            hblank(y, 1, 0);
        end
        run_px(4, 0, 7, 1'b1, 1, 0);
        run_px(4, 636, 639, 1'b1, 1, 0);
        hblank(4, 1, 0);
        for (int y = 5; y < 480; y++) begin
            run_px(y, 638, 639, 1'b1, 1, 0);
            hblank(y, 1, 0);
        end
        // Missed frame pulse: row base must saturate at the last image row
        for (int k = 0; k < 8; k++) begin
            run_px(479, 638, 639, 1'b1, 1, 0);
            hblank(479, 1, 0);
        end

        // Display disabled for a whole visible line; addresses still advance
        vblank_frame(1, 0);
        run_px(0, 0, 639, 1'b0, 1, 0);
        hblank(0, 1, 0);

        // Frame pulse on the row-advancing line end: next line restarts at row 0
        for (int y = 1; y < 3; y++) begin
            run_px(y, 636, 639, 1'b1, 1, 0);
            hblank(y, 1, 0);
        end
        run_px(3, 636, 638, 1'b1, 1, 0);
        drive(639, 3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0);
        hblank(3, 1, 0);
        for (int x = 0; x < 5; x++) drive(x, 4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, x / 4);

        // Offset window with blue background
        vblank_frame(0, 1);
        run_px(50, 98, 101, 1'b1, 0, 1);
        drive(102, 50, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1);
        hblank(50, 0, 1);

        // Reset in the middle of a visible line
        run_px(10, 0, 3, 1'b1, 0, 0);
        for (int i = 0; i < 3; i++) drive(4 + i, 10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0);
        check_reset("rst_mid");
        vblank_frame(1, 0);
        run_px(0, 0, 5, 1'b1, 1, 0);
        hblank(0, 1, 0);

        for (int i = 0; i < 6; i++) drive(-1, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
